// File: rtl/pagerank_div_scheduler.sv
// Per-node PageRank contribution sequencer. It reads rank and out-degree, launches the shared
// divider, writes rank/degree to the contribution BRAM, and sums the rank of dangling nodes.
module pagerank_div_scheduler #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W:0]            node_count,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [DATA_W-1:0]          pr_rdata,
    input  logic [DATA_W-1:0]          deg_rdata,
    output logic                       div_start,
    output logic [DATA_W-1:0]          div_dividend,
    output logic [DATA_W-1:0]          div_divisor,
    input  logic                       div_done,
    input  logic [DATA_W-1:0]          div_quotient,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W+ADDR_W-1:0]   dangling_sum,
    output logic                       busy,
    output logic                       done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int SUM_W = DATA_W + ADDR_W;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] MAX_NODES = CNT_W'(2 ** ADDR_W);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT_RD, S_DIVIDE, S_WAIT_DIV, S_WRITE, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SUM_W-1:0]    dsum_q, dsum_d;
    logic [CNT_W-1:0]    cnt_clamped;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        cnt_clamped = (node_count > MAX_NODES) ? MAX_NODES : node_count;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        wdata_d = wdata_q;
        dsum_d  = dsum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = cnt_clamped;
                    idx_d   = '0;
                    dsum_d  = '0;
                    state_d = (cnt_clamped == '0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                lat_d   = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (lat_q == LAT_LAST) begin
                    opa_d = pr_rdata;
                    opb_d = deg_rdata;
                    // Dangling node: no division, contribution 0, rank goes to the redistribution sum.
                    if (deg_rdata == '0) begin
                        wdata_d = '0;
                        dsum_d  = dsum_q + SUM_W'(pr_rdata);
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_DIVIDE:   state_d = S_WAIT_DIV;
            S_WAIT_DIV: begin
                if (div_done) begin
                    wdata_d = div_quotient;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if ({1'b0, idx_q} == cnt_q - CNT_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_READ;
                end
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            wdata_q <= '0;
            dsum_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wdata_q <= wdata_d;
            dsum_q  <= dsum_d;
        end
    end

    assign rd_en        = (state_q == S_READ);
    assign rd_addr      = idx_q;
    assign div_start    = (state_q == S_DIVIDE);
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;
    assign wr_en        = (state_q == S_WRITE);
    assign wr_addr      = idx_q;
    assign wr_data      = wdata_q;
    assign dangling_sum = dsum_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done         = (state_q == S_FINISH);
endmodule

// File: doc/pagerank_div_scheduler.md
Name: pagerank_div_scheduler

Overview:
Sequences the per-node PageRank contribution pass: for each node index it reads the current rank and the out-degree from two BRAMs and launches a multi-cycle divider with a start/done handshake. It writes each quotient (rank / out-degree) to the contribution BRAM. It sits between the rank/degree BRAMs and the shared divider. It also accumulates the rank of dangling (zero out-degree) nodes for the later redistribution stage.

Parameters:
ADDR_W, 4, node index width; up to 2^ADDR_W nodes
DATA_W, 32, rank / degree / quotient width
RD_LAT, 1, BRAM read latency in cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; begins a pass when idle
node_count  input  ADDR_W+1  number of nodes in the pass, sampled on start; 0 allowed
rd_en  output  1  read strobe to rank and degree BRAMs
rd_addr  output  ADDR_W  shared read address
pr_rdata  input  DATA_W  rank read data, valid RD_LAT cycles after rd_en
deg_rdata  input  DATA_W  out-degree read data, same timing
div_start  output  1  one-cycle launch pulse to divider
div_dividend  output  DATA_W  rank operand, held stable from div_start until div_done
div_divisor  output  DATA_W  degree operand, held stable likewise
div_done  input  1  one-cycle pulse; quotient valid this cycle
div_quotient  input  DATA_W  divider result
wr_en  output  1  write strobe to contribution BRAM
wr_addr  output  ADDR_W  write address (= node index)
wr_data  output  DATA_W  contribution value
dangling_sum  output  DATA_W+ADDR_W  sum of ranks of zero-degree nodes in last/current pass
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; all outputs 0, including dangling_sum, rd_addr and wr_addr.
- FSM states: IDLE, READ, WAIT_RD, DIVIDE, WAIT_DIV, WRITE, FINISH.
- IDLE: on start, latch node_count into cnt_r, clear idx and dangling_sum.
  - If the latched count = 0: go to FINISH.
  - Otherwise: go to READ.
  - start is ignored in every other state (no restart, no queuing).
- READ: rd_en=1 for 1 cycle, rd_addr=idx; go to WAIT_RD.
- WAIT_RD: stay RD_LAT cycles; on the last cycle capture pr_rdata/deg_rdata into operand registers.
  - If deg = 0: go to WRITE with wr_data=0, and add the zero-extended rank to dangling_sum.
  - Otherwise: go to DIVIDE.
- DIVIDE: div_start=1 for exactly 1 cycle with operands driven; go to WAIT_DIV.
- WAIT_DIV: wait for div_done.
  - div_done is sampled only in WAIT_DIV; a div_done in any other state is ignored.
  - No timeout.
  - On div_done, register div_quotient as wr_data and go to WRITE.
- WRITE: wr_en=1 for 1 cycle, wr_addr=idx.
  - If idx = cnt_r-1: go to FINISH.
  - Otherwise: idx+1, go to READ.
- FINISH: done=1 for 1 cycle, busy drops the same cycle; go to IDLE.
- Per-node cycle cost:
  - Nonzero degree: 1 + RD_LAT + 1 + L_div + 1, where L_div = cycles from div_start to div_done (>=1).
  - Zero degree: 2 + RD_LAT.
- Register stability: dangling_sum holds its final value until the next accepted start; wr_data holds between writes.
- Width rules: no saturation on dangling_sum; its width cannot overflow for ≤2^ADDR_W nodes. Quotient passed through unmodified (truncating integer division by the divider).
- node_count > 2^ADDR_W: clamp to 2^ADDR_W.
- Reset mid-pass: immediate return to IDLE; no done pulse; div_start is not reissued; a later div_done is ignored.

Test Plan:
- Reset, then node_count=3, rank={100,60,90}, deg={4,0,3}, divider stub L_div=4:
  - writes (0,25),(1,0),(2,30); dangling_sum=60; done once.
  - Node 0 write occurs 8 cycles after first rd_en (RD_LAT=1).
- Single node rank=15700, deg=11 -> one div_start with operands 15700/11, wr_data=1427, one wr_en, done.
- node_count=0 -> done pulse 2 cycles after start; zero rd_en/div_start/wr_en; dangling_sum=0.
- start pulsed again while busy (during WAIT_DIV) -> ignored: same write sequence, single done; spurious div_done injected in READ -> no effect.
- reset asserted during WAIT_DIV of node 1 of 4 -> all outputs 0 immediately; late div_done -> no write; new start then completes all 4 nodes correctly.
- All 16 nodes deg=0, rank=0xFFFFFFFF -> no div_start, 16 writes of 0, dangling_sum=0xFFFFFFFF0 (no overflow).
